// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES round widths, E/P tables, S-box tables and helper functions
package des_pkg;

  localparam int DES_HALF_W = 32;
  localparam int DES_KEY_W  = 48;

  // Bit 0 of every vector is DES bit 1 (the MSB).
  typedef logic [0:DES_HALF_W-1] half_t;
  typedef logic [0:DES_KEY_W-1]  key_t;

  localparam int E_TABLE [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int P_TABLE [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // One 256-bit word per box: 64 nibbles, row-major, leftmost nibble = row 0 col 0.
  localparam logic [255:0] SBOX_TABLE [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic key_t des_expand(input half_t r);
    key_t x;
    x = '0;
    for (int i = 0; i < DES_KEY_W; i++) begin
      x[6'(i)] = r[5'(E_TABLE[6'(i)] - 1)];
    end
    return x;
  endfunction

  function automatic half_t des_permute_p(input half_t s);
    half_t y;
    y = '0;
    for (int i = 0; i < DES_HALF_W; i++) begin
      y[5'(i)] = s[5'(P_TABLE[5'(i)] - 1)];
    end
    return y;
  endfunction

  // Row comes from the outer bits, column from the inner four.
  function automatic logic [3:0] des_sbox_lookup(input logic [2:0] idx, input logic [0:5] b);
    logic [5:0]   k;
    logic [255:0] t;
    k = {b[0], b[5], b[1:4]};
    t = SBOX_TABLE[idx] >> {6'd63 - k, 2'b00};
    return t[3:0];
  endfunction

endpackage

// File: rtl/des_feistel_round_if.sv
// rtl/des_feistel_round_if.sv - operand/result handshake bundle for the DES round datapath
interface des_feistel_round_if;
  import des_pkg::*;

  logic  wInValid;
  logic  wInReady;
  half_t wInL;
  half_t wInR;
  key_t  wInKey;
  logic  wOutValid;
  logic  wOutReady;
  half_t wOutL;
  half_t wOutR;

  modport master (
    output wInValid, wInL, wInR, wInKey, wOutReady,
    input  wInReady, wOutValid, wOutL, wOutR
  );

  modport slave (
    input  wInValid, wInL, wInR, wInKey, wOutReady,
    output wInReady, wOutValid, wOutL, wOutR
  );
endinterface

// File: rtl/des_sbox.sv
// rtl/des_sbox.sv - one DES substitution box selected by IDX (0 = S1 .. 7 = S8)
module des_sbox
  import des_pkg::*;
#(
  parameter logic [2:0] IDX = 3'd0
) (
  input  logic [0:5] din,
  output logic [3:0] dout
);
  assign dout = des_sbox_lookup(IDX, din);
endmodule

// File: rtl/des_sbox_layer.sv
// rtl/des_sbox_layer.sv - eight S-boxes mapping the 48-bit key-mixed word to 32 bits
module des_sbox_layer
  import des_pkg::*;
(
  input  key_t  x,
  output half_t s
);
  des_sbox #(.IDX(3'd0)) u_s1box (.din(x[0:5]),   .dout(s[0:3]));
  des_sbox #(.IDX(3'd1)) u_s2box (.din(x[6:11]),  .dout(s[4:7]));
  des_sbox #(.IDX(3'd2)) u_s3box (.din(x[12:17]), .dout(s[8:11]));
  des_sbox #(.IDX(3'd3)) u_s4box (.din(x[18:23]), .dout(s[12:15]));
  des_sbox #(.IDX(3'd4)) u_s5box (.din(x[24:29]), .dout(s[16:19]));
  des_sbox #(.IDX(3'd5)) u_s6box (.din(x[30:35]), .dout(s[20:23]));
  des_sbox #(.IDX(3'd6)) u_s7box (.din(x[36:41]), .dout(s[24:27]));
  des_sbox #(.IDX(3'd7)) u_s8box (.din(x[42:47]), .dout(s[28:31]));
endmodule

// File: rtl/des_feistel_round.sv
// rtl/des_feistel_round.sv - two-stage valid/ready pipeline computing one DES Feistel round
module des_feistel_round
  import des_pkg::*;
(
  input  logic               wClk,
  input  logic               wResetN,
  des_feistel_round_if.slave bus
);

  logic  v1, v2;
  half_t l1, r1;
  key_t  x1;
  half_t s_word;
  half_t out_l, out_r;
  logic  advance1;
  logic  load1;

  // Stage 1 drains whenever stage 2 is empty or being emptied downstream.
  assign advance1     = v1 & (~v2 | bus.wOutReady);
  assign bus.wInReady = ~v1 | advance1;
  assign load1        = bus.wInValid & bus.wInReady;

  always_ff @(posedge wClk or negedge wResetN) begin
    if (!wResetN) begin
      v1 <= 1'b0;
      l1 <= '0;
      r1 <= '0;
      x1 <= '0;
    end else begin
      if (bus.wInReady) begin
        v1 <= bus.wInValid;
      end
      if (load1) begin
        l1 <= bus.wInL;
        r1 <= bus.wInR;
        x1 <= des_expand(bus.wInR) ^ bus.wInKey;
      end
    end
  end

  des_sbox_layer u_sbox_layer (
    .x (x1),
    .s (s_word)
  );

  always_ff @(posedge wClk or negedge wResetN) begin
    if (!wResetN) begin
      v2    <= 1'b0;
      out_l <= '0;
      out_r <= '0;
    end else begin
      if (~v2 | bus.wOutReady) begin
        v2 <= v1;
      end
      if (advance1) begin
        out_l <= r1;
        out_r <= l1 ^ des_permute_p(s_word);
      end
    end
  end

  assign bus.wOutValid = v2;
  assign bus.wOutL     = out_l;
  assign bus.wOutR     = out_r;

endmodule

// File: tb/tb_des_feistel_round.sv
// tb/tb_des_feistel_round.sv - directed and random checks of des_feistel_round against a table-driven model
module tb_des_feistel_round;

  logic clk;
  logic rst_n;

  des_feistel_round_if bus ();

  des_feistel_round dut (
    .wClk    (clk),
    .wResetN (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };
  int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };
  // 64 hex characters per box, index = row*16 + col.
  string SB [8] = '{
    "E4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D",
    "F18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9",
    "A09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C",
    "7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E",
    "2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453",
    "C1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D",
    "4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C",
    "D2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B"
  };

  int n_vec = 0;
  int n_err = 0;
  int n_pop = 0;
  int n_acc = 0;
  logic [63:0] exp_q [$];
  logic        hold_pending = 1'b0;
  logic [64:0] held;

  function automatic logic [3:0] hexval(input byte c);
    if (c >= "A") return 4'(c - 8'd55);
    return 4'(c - 8'd48);
  endfunction

  // Plain-arithmetic DES round on MSB-first 32/48-bit numbers.
  function automatic logic [63:0] ref_round(input logic [31:0] l, input logic [31:0] r,
                                            input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, p;
    int six, row, col;
    x = '0;
    for (int i = 0; i < 48; i++) x = {x[46:0], r[32 - E_T[i]]};
    x = x ^ k;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      six = int'((x >> (42 - 6 * j)) & 48'h3F);
      row = ((six >> 4) & 2) | (six & 1);
      col = (six >> 1) & 15;
      s = {s[27:0], hexval(SB[j][row * 16 + col])};
    end
    p = '0;
    for (int i = 0; i < 32; i++) p = {p[30:0], s[32 - P_T[i]]};
    return {r, l ^ p};
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Sample at the falling edge, then return just after the next rising edge.
  task automatic cycle();
    logic [63:0] e;
    @(negedge clk);
    if (hold_pending) check("hold_stable", {bus.wOutValid, bus.wOutL, bus.wOutR}, held);
    if (bus.wInValid && bus.wInReady) begin
      exp_q.push_back(ref_round(bus.wInL, bus.wInR, bus.wInKey));
      n_acc++;
    end
    if (bus.wOutValid && bus.wOutReady) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL spurious_out observed=%h%h expected=none", bus.wOutL, bus.wOutR);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("result", {bus.wOutL, bus.wOutR}, e);
      end
      n_pop++;
    end
    hold_pending = bus.wOutValid & ~bus.wOutReady;
    held = {bus.wOutValid, bus.wOutL, bus.wOutR};
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(input logic v);
    bus.wInValid = v;
    bus.wInL     = $urandom();
    bus.wInR     = $urandom();
    bus.wInKey   = 48'({$urandom(), $urandom()});
  endtask

  task automatic drain(input int budget);
    bus.wInValid  = 1'b0;
    bus.wOutReady = 1'b1;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cycle();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic directed(input string tag, input logic [31:0] l, input logic [31:0] r,
                          input logic [47:0] k, input logic [31:0] exp_r);
    bus.wOutReady = 1'b1;
    bus.wInValid  = 1'b1;
    bus.wInL = l; bus.wInR = r; bus.wInKey = k;
    cycle();
    bus.wInValid = 1'b0;
    check({tag, "_valid_e1"}, bus.wOutValid, 0);
    cycle();
    check({tag, "_valid_e2"}, bus.wOutValid, 1);
    check({tag, "_out"}, {bus.wOutL, bus.wOutR}, {r, exp_r});
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, a0;
    rst_n = 1'b0;
    bus.wInValid = 1'b0; bus.wOutReady = 1'b0;
    bus.wInL = '0; bus.wInR = '0; bus.wInKey = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.wOutValid, 0);
    check("rst_out", {bus.wOutL, bus.wOutR}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", bus.wInReady, 1);

    directed("zero", 32'h0, 32'h0, 48'h0, 32'hD8D8DBBC);
    directed("lpass", 32'hFFFFFFFF, 32'h0, 48'h0, 32'h27272443);

    // Back-to-back stream: 16 results must appear within 18 cycles.
    bus.wOutReady = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 16; i++) begin
      drive_rand(1'b1);
      cycle();
    end
    bus.wInValid = 1'b0;
    repeat (2) cycle();
    check("stream_count", n_pop - p0, 16);
    check("stream_empty", exp_q.size(), 0);

    // Back-pressure from an empty pipe.
    bus.wOutReady = 1'b0;
    a0 = n_acc;
    p0 = n_pop;
    for (int i = 0; i < 5; i++) begin
      drive_rand(1'b1);
      cycle();
    end
    check("bp_accepts", n_acc - a0, 2);
    check("bp_in_ready", bus.wInReady, 0);
    check("bp_valid", bus.wOutValid, 1);
    drain(10);
    check("bp_results", n_pop - p0, 2);

    // Reset with two operands in flight.
    bus.wOutReady = 1'b0;
    drive_rand(1'b1);
    cycle();
    drive_rand(1'b1);
    cycle();
    bus.wInValid = 1'b0;
    check("mid_valid_pre", bus.wOutValid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.wOutValid, 0);
    check("mid_rst_out", {bus.wOutL, bus.wOutR}, 64'd0);
    exp_q.delete();
    hold_pending = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    check("mid_in_ready", bus.wInReady, 1);
    bus.wOutReady = 1'b1;
    p0 = n_pop;
    repeat (4) cycle();
    check("mid_no_stale", n_pop - p0, 0);

    // Random traffic with random valid/ready.
    for (int i = 0; i < 10000; i++) begin
      drive_rand(1'($urandom_range(0, 1)));
      bus.wOutReady = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
